// File: rtl/store_buf_pkg.sv
// Shared types and constants for the MEM-stage store buffer.
package store_buf_pkg;
  localparam int SB_DEPTH   = 4;
  localparam int SB_AW      = 32;
  localparam int PTR_W      = $clog2(SB_DEPTH);
  localparam int BYTE_LANES = 4;

  typedef struct packed {
    logic [SB_AW-3:0]      word_addr;
    logic [BYTE_LANES-1:0] wstrb;
    logic [31:0]           wdata;
  } sb_entry_t;
endpackage

// File: rtl/store_buf_merge.sv
// Byte-lane merge of a younger store into an already queued entry.
module store_buf_merge
  import store_buf_pkg::*;
(
  input  logic [31:0]           old_data,
  input  logic [BYTE_LANES-1:0] old_strb,
  input  logic [31:0]           new_data,
  input  logic [BYTE_LANES-1:0] new_strb,
  output logic [31:0]           merged_data,
  output logic [BYTE_LANES-1:0] merged_strb
);

  // Newer lanes overwrite older ones; untouched lanes keep the queued bytes.
  always_comb begin
    merged_strb = old_strb | new_strb;
    merged_data = old_data;
    for (int b = 0; b < BYTE_LANES; b++) begin
      if (new_strb[b]) begin
        merged_data[8*b +: 8] = new_data[8*b +: 8];
      end else begin
        merged_data[8*b +: 8] = old_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue with single-outstanding bus write and load conflict check.
// Optional write merging into the youngest entry is enabled by STORE_BUF_MERGE_EN.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_wdata,
  input  logic [3:0]    st_b_w_en,
  output logic          data_req,
  output logic          data_wr,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [31:0]   data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic          sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  sb_entry_t     mem_r [DEPTH];
  logic [PW-1:0] head_r, tail_r, tail_prev_s, ld_idx_s;
  logic [PW:0]   count_r;
  logic          pend_r;
  logic [AW-3:0] st_word_s;
  logic          merge_ok_s, accept_s, enq_s, deq_s, req_s, ld_hit_s;
  sb_entry_t     head_s;
  logic          unused_s;

  assign unused_s    = ^{st_addr[1:0], ld_addr[1:0]};
  assign st_word_s   = st_addr[AW-1:2];
  assign tail_prev_s = tail_r - PTR_ONE;
  assign head_s      = mem_r[head_r];
  assign req_s       = (count_r != CNT_ZERO) && !pend_r;

`ifdef STORE_BUF_MERGE_EN
  logic [31:0]           merged_data_s;
  logic [BYTE_LANES-1:0] merged_strb_s;
  logic                  merge_s;

  store_buf_merge u_merge (
    .old_data    (mem_r[tail_prev_s].wdata),
    .old_strb    (mem_r[tail_prev_s].wstrb),
    .new_data    (st_wdata),
    .new_strb    (st_b_w_en),
    .merged_data (merged_data_s),
    .merged_strb (merged_strb_s)
  );

  // The youngest entry may only absorb a store when it is not the one on the bus.
  assign merge_ok_s = (count_r != CNT_ZERO)
                   && (mem_r[tail_prev_s].word_addr == st_word_s)
                   && ((tail_prev_s != head_r) || pend_r);
  assign merge_s    = accept_s && merge_ok_s;
`else
  assign merge_ok_s = 1'b0;
`endif

  assign st_ready = (count_r < CNT_FULL) || merge_ok_s;
  assign accept_s = st_valid && st_ready && (st_b_w_en != 4'b0000);
  assign enq_s    = accept_s && !merge_ok_s;
  assign deq_s    = req_s && data_addr_ok;

  // Pointer, occupancy and outstanding-response bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CNT_ZERO;
      pend_r  <= 1'b0;
    end else begin
      if (enq_s) tail_r <= tail_r + PTR_ONE;
      if (deq_s) head_r <= head_r + PTR_ONE;
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (deq_s) begin
        pend_r <= 1'b1;
      end else if (data_data_ok) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Entry payload storage; contents are only meaningful below count_r.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[tail_r] <= '{word_addr: st_word_s, wstrb: st_b_w_en, wdata: st_wdata};
`ifdef STORE_BUF_MERGE_EN
    end else if (merge_s) begin
      mem_r[tail_prev_s].wstrb <= merged_strb_s;
      mem_r[tail_prev_s].wdata <= merged_data_s;
`endif
    end
  end

  // Load conflict: any queued entry (head included until it is accepted) on the same word.
  always_comb begin
    ld_hit_s = 1'b0;
    ld_idx_s = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      ld_idx_s = head_r + PW'(i);
      if (((PW+1)'(i) < count_r) && (mem_r[ld_idx_s].word_addr == ld_addr[AW-1:2])) begin
        ld_hit_s = 1'b1;
      end else begin
        ld_hit_s = ld_hit_s;
      end
    end
  end

  assign data_req   = req_s;
  assign data_wr    = req_s;
  assign data_addr  = {head_s.word_addr, 2'b00};
  assign data_wstrb = head_s.wstrb;
  assign data_wdata = head_s.wdata;
  assign ld_hit     = ld_hit_s;
  assign sb_empty   = (count_r == CNT_ZERO) && !pend_r;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the store byte-enable generator in the MEM stage.
- Queues committed stores (word address, aligned data, 4-bit byte enables) and drains them in order to the data SRAM-like bus.
- Gives the pipeline a load-address conflict check so that loads stall while an older store to the same word is still queued.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- AW, 32, address width; entries store AW-2 word-address bits.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept or merge this cycle
- st_addr  in  AW  byte address; bits [1:0] are ignored
- st_wdata  in  32  data already byte-lane aligned
- st_b_w_en  in  4  byte write enables from the byte-enable generator
- data_req  out  1  bus request
- data_wr  out  1  constant 1 while data_req is high
- data_addr  out  AW  {head word address, 2'b00}
- data_wstrb  out  4  head byte enables
- data_wdata  out  32  head data
- data_addr_ok  in  1  bus accepted the request
- data_data_ok  in  1  bus completed the write
- ld_addr  in  AW  address of the load in MEM stage
- ld_hit  out  1  a queued entry matches ld_addr[AW-1:2]
- sb_empty  out  1  no entries queued and no response outstanding

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Enqueue: occurs on st_valid && st_ready && st_b_w_en!=0. A store with st_b_w_en==0 is accepted and dropped.
- st_ready = (count<DEPTH). Never combinationally dependent on data_addr_ok, so there is no bypass when full.
- Response tracking: single-bit pend_resp. Set on data_req && data_addr_ok; cleared on data_data_ok. A data_data_ok with pend_resp==0 is ignored.
- data_req = (count!=0) && !pend_resp, so at most one write is outstanding.
- data_addr, data_wstrb and data_wdata come from the head entry and stay stable while data_req is high.
- Dequeue: the head entry is freed and head advances on data_req && data_addr_ok.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance. This is legal at count==DEPTH, but st_ready was already low that cycle, so no enqueue occurs then.
- ld_hit: combinational OR over all valid entries of (entry word address == ld_addr[AW-1:2]).
  - The entry being enqueued in the same cycle is excluded.
  - The head entry is included until the cycle of its data_addr_ok.
- sb_empty = (count==0) && !pend_resp.
- Latency: a store accepted into an empty buffer with no pending response raises data_req on the next cycle.
- Reset: asserting resetn low at any time, including with a request outstanding, immediately clears the following. Any in-flight bus response after reset is ignored.
  - count, head, tail, pend_resp = 0.
  - data_req = 0, ld_hit = 0, sb_empty = 1, st_ready = 1.
  - Entry contents are don't-care.

Optional Feature:
- Macro: STORE_BUF_MERGE_EN.
- When defined, an incoming store merges into the youngest entry (tail-1) instead of allocating, when all of the following hold:
  - count!=0;
  - word addresses are equal;
  - the youngest entry is not currently driving data_req, i.e. (tail-1)!=head or pend_resp==1.
- Merge rules:
  - wstrb becomes old | new; each byte lane with new enable set takes the new data.
  - count is unchanged.
  - st_ready = (count<DEPTH) || merge_possible.
- When undefined: every accepted store allocates a new entry, with no merge logic.

Decomposition:
- Package store_buf_pkg holds:
  - entry struct {word_addr[AW-3:0], wstrb[3:0], wdata[31:0]};
  - localparam PTR_W = $clog2(DEPTH);
  - the byte-lane count constant 4.
- One natural sub-module, store_buf_merge: combinational byte-lane merge of (old data, old strb, new data, new strb). It is instantiated only under STORE_BUF_MERGE_EN.

Test Plan:
- Single store: addr 0x100, wdata 0xAABBCCDD, b_w_en 0001 -> next cycle data_req=1, data_addr=0x100, wstrb=0001; on addr_ok the entry frees; sb_empty=1 one cycle after data_ok.
- Fill to full (DEPTH=4, bus holds addr_ok low): after 4 stores st_ready=0. Then pulse addr_ok once -> st_ready=1 next cycle and order is preserved across pointer wrap.
- Load conflict: queue a store to 0x2004, ld_addr=0x2006 -> ld_hit=1; ld_addr=0x2008 -> ld_hit=0; ld_hit drops the cycle after addr_ok for that entry.
- Back-to-back with one outstanding: two stores queued, addr_ok given but data_ok delayed 3 cycles -> data_req stays low until data_ok, then the second request issues.
- Reset mid-operation: resetn low while pend_resp=1 and count=3 -> data_req=0 and sb_empty=1 immediately; a stray data_ok after reset has no effect.
- With STORE_BUF_MERGE_EN:
  - store 0x300 strb 0001 data 0x000000AA while the head is busy, then store 0x300 strb 0100 data 0x00BB0000 -> count stays 1 extra entry, issued wstrb=0101, wdata=0x00BB00AA.
  - Without the macro, the same stimulus gives two separate bus writes.
